sb_cfg_mux_bank: RTL and testbench

//  Parametrised switch-block routing stage: N_MUX output muxes, each selecting 1 of MUX_SIZE track/pin inputs.

---
 rtl/sb_cfg_mux_bank.sv | 196 +++++++++++++++++++
 tb/tb_sb_cfg_mux_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_mux_bank.sv
// -----------------------------------------------------------------------------
// sb_cfg_mux_bank
//
// Switch-block routing stage: N_MUX output muxes, each picking one of MUX_SIZE
// track/pin inputs. Every mux selector is double-buffered. A shadow bank is
// written through a valid/ready word port. A commit then copies the shadow
// bank into the active bank, one entry per cycle. Only the active bank steers
// the fabric, so partially written configurations never reach mux_out.
//
// Optional feature macro: CFG_READBACK_EN
//   When defined, adds a registered readback port for the active bank
//   (rb_addr in, rb_data out, 1-cycle latency, 0 for out-of-range addresses).
//
// Ports
//   prog_clk    in   1               configuration/system clock
//   prog_rst_n  in   1               synchronous active-low reset
//   cfg_valid   in   1               write request
//   cfg_ready   out  1               write accepted when cfg_valid && cfg_ready
//   cfg_addr    in   ADDR_W          target mux index
//   cfg_data    in   SEL_W           selector value
//   cfg_commit  in   1               request shadow->active copy (sampled in idle)
//   cfg_busy    out  1               commit in progress
//   cfg_err     out  1               sticky: bad address or selector seen
//   mux_in      in   N_MUX*MUX_SIZE  mux k input j at bit k*MUX_SIZE+j
//   mux_out     out  N_MUX           mux k output
//   rb_addr     in   ADDR_W          (CFG_READBACK_EN) active-bank read index
//   rb_data     out  SEL_W           (CFG_READBACK_EN) registered read data
// -----------------------------------------------------------------------------
module sb_cfg_mux_bank #(
  parameter int unsigned N_MUX    = 12,
  parameter int unsigned MUX_SIZE = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                      prog_clk,
  input  logic                      prog_rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [SEL_W-1:0]          cfg_data,
  input  logic                      cfg_commit,
  output logic                      cfg_busy,
  output logic                      cfg_err,
  input  logic [N_MUX*MUX_SIZE-1:0] mux_in,
  output logic [N_MUX-1:0]          mux_out
`ifdef CFG_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]         rb_addr,
  output logic [SEL_W-1:0]          rb_data
`endif
);

  // One spare bit so the counter can hold N_MUX without wrapping.
  localparam int unsigned CNT_W = $clog2(N_MUX) + 1;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_MUX - 1);
  localparam logic [MUX_SIZE-1:0] SelBase = {{(MUX_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StCommit} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] shadow_q [N_MUX];
  logic [SEL_W-1:0] shadow_d [N_MUX];
  logic [SEL_W-1:0] active_q [N_MUX];
  logic [SEL_W-1:0] active_d [N_MUX];

  logic wr_bad;

  // A write is rejected if it targets a nonexistent mux or selects an input
  // the mux does not have; the handshake still completes.
  assign wr_bad = (32'(cfg_addr) >= N_MUX) || (32'(cfg_data) >= MUX_SIZE);

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    cfg_ready = 1'b0;
    cfg_busy  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        // cfg_ready is constant 1 here, so cfg_valid alone marks a handshake.
        if (cfg_valid) begin
          if (wr_bad) begin
            err_d = 1'b1;
          end else begin
            for (int unsigned k = 0; k < N_MUX; k++) begin
              if (32'(cfg_addr) == k) begin
                shadow_d[k] = cfg_data;
              end
            end
          end
        end
        // A same-cycle write lands in shadow on this edge, so the copy that
        // starts next cycle already sees it. The error clear overrides a set.
        if (cfg_commit) begin
          state_d = StCommit;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      StCommit: begin
        cfg_busy = 1'b1;
        for (int unsigned k = 0; k < N_MUX; k++) begin
          if (32'(cnt_q) == k) begin
            active_d[k] = shadow_q[k];
          end
        end
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous active-low reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < N_MUX; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign cfg_err = err_q;

  // ---------------------------------------------------------------------------
  // Routing muxes: purely combinational from the active bank and mux_in.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_MUX; k++) begin : g_mux
    logic [MUX_SIZE-1:0] row;
    logic [MUX_SIZE-1:0] sel_oh;
    logic                sel_ok;

    assign row    = mux_in[k*MUX_SIZE +: MUX_SIZE];
    assign sel_oh = SelBase << active_q[k];
    // Out-of-range selectors cannot be written, but still drive a defined 0.
    assign sel_ok = (32'(active_q[k]) < MUX_SIZE);
    assign mux_out[k] = sel_ok & (|(row & sel_oh));
  end

`ifdef CFG_READBACK_EN
  // ---------------------------------------------------------------------------
  // Registered readback of the active bank.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] rb_q, rb_d;

  always_comb begin
    rb_d = '0;
    for (int unsigned k = 0; k < N_MUX; k++) begin
      if (32'(rb_addr) == k) begin
        rb_d = active_q[k];
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  assign rb_data = rb_q;
`endif

endmodule

// File: tb/tb_sb_cfg_mux_bank.sv
// -----------------------------------------------------------------------------
// tb_sb_cfg_mux_bank
//
// Scoreboard bench for sb_cfg_mux_bank. The stimulus process drives one cycle
// at a time and pushes the expected outputs for that cycle, computed from a
// behavioural model (shadow/active arrays and a remaining-commit-cycles
// count). A monitor pops one expectation per falling edge and compares.
// MUX_SIZE=6 exercises a non-power-of-two mux and reachable selector errors.
// -----------------------------------------------------------------------------
module tb_sb_cfg_mux_bank;

  localparam int N  = 12;
  localparam int M  = 6;
  localparam int SW = 3;
  localparam int AW = 4;

  logic            prog_clk;
  logic            prog_rst_n;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [AW-1:0]   cfg_addr;
  logic [SW-1:0]   cfg_data;
  logic            cfg_commit;
  logic            cfg_busy;
  logic            cfg_err;
  logic [N*M-1:0]  mux_in;
  logic [N-1:0]    mux_out;
  logic [AW-1:0]   rb_addr;
  logic [SW-1:0]   rb_data;

  sb_cfg_mux_bank #(
    .N_MUX    (N),
    .MUX_SIZE (M),
    .SEL_W    (SW),
    .ADDR_W   (AW)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .mux_in     (mux_in),
    .mux_out    (mux_out)
`ifdef CFG_READBACK_EN
    ,
    .rb_addr    (rb_addr),
    .rb_data    (rb_data)
`endif
  );

`ifndef CFG_READBACK_EN
  assign rb_data = '0;
`endif

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  typedef struct packed {
    logic [N-1:0]  mux;
    logic          ready;
    logic          busy;
    logic          err;
    logic [SW-1:0] rb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model.
  int  m_shadow [N];
  int  m_active [N];
  int  m_left;   // commit cycles still to run; 0 means idle
  bit  m_err;
  int  m_rb;
  bit  m_known = 1'b0;
  bit  rand_in = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge prog_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mux_out", 32'(mux_out), 32'(e.mux));
        check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
        check("cfg_busy", 32'(cfg_busy), 32'(e.busy));
        check("cfg_err", 32'(cfg_err), 32'(e.err));
`ifdef CFG_READBACK_EN
        check("rb_data", 32'(rb_data), 32'(e.rb));
`endif
      end
    end
  end

  function automatic exp_t expected();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.mux[k] = (m_active[k] < M) ? mux_in[k*M + m_active[k]] : 1'b0;
    end
    e.ready = (m_left == 0);
    e.busy  = (m_left != 0);
    e.err   = m_err;
    e.rb    = SW'(m_rb);
    return e;
  endfunction

  task automatic model_edge();
    int idx;
    if (!prog_rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_shadow[k] = 0;
        m_active[k] = 0;
      end
      m_left  = 0;
      m_err   = 1'b0;
      m_rb    = 0;
      m_known = 1'b1;
    end else begin
      m_rb = (int'(rb_addr) < N) ? m_active[rb_addr] : 0;
      if (m_left == 0) begin
        if (cfg_valid) begin
          if (int'(cfg_addr) < N && int'(cfg_data) < M) m_shadow[cfg_addr] = int'(cfg_data);
          else m_err = 1'b1;
        end
        if (cfg_commit) begin
          m_err  = 1'b0;
          m_left = N;
        end
      end else begin
        idx = N - m_left;
        m_active[idx] = m_shadow[idx];
        m_left--;
      end
    end
  endtask

  // One clock cycle of stimulus.
  task automatic step(input logic rst_n, input logic v, input int a, input int d,
                      input logic c);
    prog_rst_n = rst_n;
    cfg_valid  = v;
    cfg_addr   = AW'(a);
    cfg_data   = SW'(d);
    cfg_commit = c;
    rb_addr    = AW'($urandom_range(0, 15));
    if (rand_in) begin
      for (int i = 0; i < N*M; i++) mux_in[i] = 1'($urandom);
    end
    if (m_known) exp_q.push_back(expected());
    @(posedge prog_clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int busy_cnt;
    prog_rst_n = 1'b0;
    cfg_valid  = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    rb_addr    = '0;

    // Reset with every input high except input 0 of each mux.
    mux_in = '1;
    for (int k = 0; k < N; k++) mux_in[k*M] = 1'b0;
    step(1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);

    // Shadow write alone must not disturb mux 3.
    step(1'b1, 1'b1, 3, 5, 1'b0);
    mux_in = '0;
    mux_in[3*M + 5] = 1'b1;
    idle(3);

    // Commit: busy for exactly N cycles, then mux 3 follows input 5.
    step(1'b1, 1'b0, 0, 0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 40 && cfg_busy; i++) begin
      busy_cnt++;
      idle(1);
    end
    check("commit_busy_cycles", 32'(busy_cnt), 32'(N));
    idle(2);

    // Write and commit in the same idle cycle.
    mux_in = '0;
    mux_in[M-1] = 1'b1;
    step(1'b1, 1'b1, 0, M-1, 1'b1);
    idle(N + 2);

    // Bad address, then bad selector; commit clears the sticky error.
    step(1'b1, 1'b1, 12, 1, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 2, 7, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 15, 0, 1'b1);
    idle(N + 2);

    // Reset part-way through a commit.
    rand_in = 1'b1;
    for (int k = 0; k < N; k++) step(1'b1, 1'b1, k, (k + 1) % M, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    idle(5);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    idle(N + 2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           1'($urandom),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) == 0));
    end
    idle(N + 2);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge prog_clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
